// File: rtl/ram_addr_sequencer.sv
// ram_addr_sequencer
//   Address/write-enable sequencer for a dual-port image RAM. It fills both RAM ports from a
//   load stream, with even words going to port A and odd words to port B. It then serves
//   point frames: each frame issues one read-address pair per cycle for NPTS match points,
//   followed by a base point that is used on both ports.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   start                     level enable; when low, the block returns to idle
//   ld_valid/ld_last/ld_data  load stream; low half of ld_data goes to port A, high half to B
//   pts_valid/pts_ready       point-frame handshake
//   pts_xi/yi, pts_xo/yo      per-point fixed-point coords for port A / port B
//   xb, yb                    base point coordinates
//   addr_*, we_*, wdata_*     RAM port controls (registered)
//   rd_valid, rd_idx          read pair valid and the point index (NPTS = base point)
//   oob_a, oob_b              point lies outside the image; its address is forced to 0
//   done                      single-cycle pulse that accompanies the base read pair
module ram_addr_sequencer #(
    parameter int unsigned COORD_W = 14,
    parameter int unsigned FRAC_W  = 4,
    parameter int unsigned NPTS    = 4,
    parameter int unsigned IMG_W   = 180,
    parameter int unsigned IMG_H   = 182,
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned DATA_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       ld_valid,
    input  logic                       ld_last,
    input  logic [2*DATA_W-1:0]        ld_data,
    input  logic                       pts_valid,
    output logic                       pts_ready,
    input  logic [NPTS*COORD_W-1:0]    pts_xi,
    input  logic [NPTS*COORD_W-1:0]    pts_yi,
    input  logic [NPTS*COORD_W-1:0]    pts_xo,
    input  logic [NPTS*COORD_W-1:0]    pts_yo,
    input  logic [COORD_W-1:0]         xb,
    input  logic [COORD_W-1:0]         yb,
    output logic [ADDR_W-1:0]          addr_a,
    output logic [ADDR_W-1:0]          addr_b,
    output logic                       we_a,
    output logic                       we_b,
    output logic [DATA_W-1:0]          wdata_a,
    output logic [DATA_W-1:0]          wdata_b,
    output logic                       rd_valid,
    output logic [$clog2(NPTS+1)-1:0]  rd_idx,
    output logic                       oob_a,
    output logic                       oob_b,
    output logic                       done
);

    localparam int unsigned IDX_W = $clog2(NPTS + 1);
    localparam int unsigned INT_W = COORD_W - FRAC_W;
    localparam int unsigned WC_W  = ADDR_W - 1;
    localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(IMG_W * IMG_H / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_BASE = IDX_W'(NPTS);

    typedef enum logic [1:0] {StIdle, StLoad, StWaitPts, StScan} state_e;

    // Returns {oob, addr}. The address is computed at full width so that no in-image
    // point can alias.
    function automatic logic [ADDR_W:0] map_pt(input logic [COORD_W-1:0] x,
                                               input logic [COORD_W-1:0] y);
        logic [INT_W-1:0] ix;
        logic [INT_W-1:0] iy;
        ix = x[COORD_W-1:FRAC_W];
        iy = y[COORD_W-1:FRAC_W];
        if (32'(ix) >= IMG_W || 32'(iy) >= IMG_H) begin
            return {1'b1, {ADDR_W{1'b0}}};
        end
        return {1'b0, ADDR_W'(32'(iy) * IMG_W + 32'(ix))};
    endfunction

    state_e                    state_q, state_d;
    logic [WC_W-1:0]           wc_q, wc_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [NPTS*COORD_W-1:0]   xi_q, xi_d, yi_q, yi_d, xo_q, xo_d, yo_q, yo_d;
    logic [COORD_W-1:0]        xb_q, xb_d, yb_q, yb_d;

    logic                      pts_ready_d, we_a_d, we_b_d, rd_valid_d;
    logic                      oob_a_d, oob_b_d, done_d;
    logic [ADDR_W-1:0]         addr_a_d, addr_b_d;
    logic [DATA_W-1:0]         wdata_a_d, wdata_b_d;
    logic [IDX_W-1:0]          rd_idx_d;

    logic                      scan_pt;
    logic [COORD_W-1:0]        sxa, sya, sxb, syb;

    always_comb begin
        state_d     = state_q;
        wc_d        = wc_q;
        idx_d       = idx_q;
        xi_d        = xi_q;
        yi_d        = yi_q;
        xo_d        = xo_q;
        yo_d        = yo_q;
        xb_d        = xb_q;
        yb_d        = yb_q;
        we_a_d      = 1'b0;
        we_b_d      = 1'b0;
        addr_a_d    = '0;
        addr_b_d    = '0;
        wdata_a_d   = '0;
        wdata_b_d   = '0;
        rd_valid_d  = 1'b0;
        rd_idx_d    = '0;
        oob_a_d     = 1'b0;
        oob_b_d     = 1'b0;
        done_d      = 1'b0;
        scan_pt     = 1'b0;
        sxa         = '0;
        sya         = '0;
        sxb         = '0;
        syb         = '0;

        if (!start) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StLoad;
                    wc_d    = '0;
                end
                StLoad: begin
                    if (ld_valid) begin
                        we_a_d    = 1'b1;
                        we_b_d    = 1'b1;
                        addr_a_d  = {wc_q, 1'b0};
                        addr_b_d  = {wc_q, 1'b1};
                        wdata_a_d = ld_data[DATA_W-1:0];
                        wdata_b_d = ld_data[2*DATA_W-1:DATA_W];
                        wc_d      = wc_q + 1'b1;
                        if (ld_last || wc_q == WC_LAST) begin
                            state_d = StWaitPts;
                        end
                    end
                end
                StWaitPts: begin
                    if (pts_valid && pts_ready) begin
                        xi_d    = pts_xi;
                        yi_d    = pts_yi;
                        xo_d    = pts_xo;
                        yo_d    = pts_yo;
                        xb_d    = xb;
                        yb_d    = yb;
                        idx_d   = '0;
                        state_d = StScan;
                        // Point 0 comes straight from the inputs so that the first read
                        // pair appears in the cycle right after acceptance.
                        scan_pt = 1'b1;
                        sxa     = pts_xi[COORD_W-1:0];
                        sya     = pts_yi[COORD_W-1:0];
                        sxb     = pts_xo[COORD_W-1:0];
                        syb     = pts_yo[COORD_W-1:0];
                    end
                end
                StScan: begin
                    if (idx_q == IDX_BASE) begin
                        state_d = StWaitPts;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        scan_pt = 1'b1;
                        if (idx_d == IDX_BASE) begin
                            sxa    = xb_q;
                            sya    = yb_q;
                            sxb    = xb_q;
                            syb    = yb_q;
                            done_d = 1'b1;
                        end else begin
                            for (int k = 0; k < int'(NPTS); k++) begin
                                if (idx_d == IDX_W'(k)) begin
                                    sxa = xi_q[k*COORD_W +: COORD_W];
                                    sya = yi_q[k*COORD_W +: COORD_W];
                                    sxb = xo_q[k*COORD_W +: COORD_W];
                                    syb = yo_q[k*COORD_W +: COORD_W];
                                end
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (scan_pt) begin
            {oob_a_d, addr_a_d} = map_pt(sxa, sya);
            {oob_b_d, addr_b_d} = map_pt(sxb, syb);
            rd_valid_d = 1'b1;
            rd_idx_d   = idx_d;
        end

        pts_ready_d = (state_d == StWaitPts);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            wc_q      <= '0;
            idx_q     <= '0;
            xi_q      <= '0;
            yi_q      <= '0;
            xo_q      <= '0;
            yo_q      <= '0;
            xb_q      <= '0;
            yb_q      <= '0;
            pts_ready <= 1'b0;
            addr_a    <= '0;
            addr_b    <= '0;
            we_a      <= 1'b0;
            we_b      <= 1'b0;
            wdata_a   <= '0;
            wdata_b   <= '0;
            rd_valid  <= 1'b0;
            rd_idx    <= '0;
            oob_a     <= 1'b0;
            oob_b     <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            wc_q      <= wc_d;
            idx_q     <= idx_d;
            xi_q      <= xi_d;
            yi_q      <= yi_d;
            xo_q      <= xo_d;
            yo_q      <= yo_d;
            xb_q      <= xb_d;
            yb_q      <= yb_d;
            pts_ready <= pts_ready_d;
            addr_a    <= addr_a_d;
            addr_b    <= addr_b_d;
            we_a      <= we_a_d;
            we_b      <= we_b_d;
            wdata_a   <= wdata_a_d;
            wdata_b   <= wdata_b_d;
            rd_valid  <= rd_valid_d;
            rd_idx    <= rd_idx_d;
            oob_a     <= oob_a_d;
            oob_b     <= oob_b_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_ram_addr_sequencer.sv
module tb_ram_addr_sequencer;

    localparam int COORD_W = 14;
    localparam int FRAC_W  = 4;
    localparam int NPTS    = 4;
    localparam int IMG_W   = 180;
    localparam int IMG_H   = 182;
    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 8;
    localparam int IDX_W   = $clog2(NPTS + 1);

    logic                      clk = 1'b0;
    logic                      rst, start, ld_valid, ld_last, pts_valid;
    logic [2*DATA_W-1:0]       ld_data;
    logic                      pts_ready;
    logic [NPTS*COORD_W-1:0]   pts_xi, pts_yi, pts_xo, pts_yo;
    logic [COORD_W-1:0]        xb, yb;
    logic [ADDR_W-1:0]         addr_a, addr_b;
    logic                      we_a, we_b, rd_valid, oob_a, oob_b, done;
    logic [DATA_W-1:0]         wdata_a, wdata_b;
    logic [IDX_W-1:0]          rd_idx;

    ram_addr_sequencer #(
        .COORD_W(COORD_W), .FRAC_W(FRAC_W), .NPTS(NPTS), .IMG_W(IMG_W),
        .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ld_valid(ld_valid), .ld_last(ld_last),
        .ld_data(ld_data), .pts_valid(pts_valid), .pts_ready(pts_ready),
        .pts_xi(pts_xi), .pts_yi(pts_yi), .pts_xo(pts_xo), .pts_yo(pts_yo),
        .xb(xb), .yb(yb), .addr_a(addr_a), .addr_b(addr_b), .we_a(we_a), .we_b(we_b),
        .wdata_a(wdata_a), .wdata_b(wdata_b), .rd_valid(rd_valid), .rd_idx(rd_idx),
        .oob_a(oob_a), .oob_b(oob_b), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    // Frame under test (plain integers) and its expected read pairs.
    int xi_v[NPTS], yi_v[NPTS], xo_v[NPTS], yo_v[NPTS];
    int xb_v, yb_v;
    int exp_a[NPTS+1], exp_b[NPTS+1];
    bit exp_oa[NPTS+1], exp_ob[NPTS+1];

    typedef struct {
        int x;
        int y;
        int exp_addr;
        bit exp_oob;
    } vec_t;
    vec_t tbl[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Reference: pixel coordinate is the integer part; outside the image -> -1.
    function automatic int ref_addr(input int x, input int y);
        int ix, iy;
        ix = x / (1 << FRAC_W);
        iy = y / (1 << FRAC_W);
        if (ix >= IMG_W || iy >= IMG_H) return -1;
        return iy * IMG_W + ix;
    endfunction

    task automatic model_frame();
        int r;
        for (int k = 0; k <= NPTS; k++) begin
            r = (k < NPTS) ? ref_addr(xi_v[k], yi_v[k]) : ref_addr(xb_v, yb_v);
            exp_a[k]  = (r < 0) ? 0 : r;
            exp_oa[k] = (r < 0);
            r = (k < NPTS) ? ref_addr(xo_v[k], yo_v[k]) : ref_addr(xb_v, yb_v);
            exp_b[k]  = (r < 0) ? 0 : r;
            exp_ob[k] = (r < 0);
        end
    endtask

    task automatic drive_pts();
        for (int k = 0; k < NPTS; k++) begin
            pts_xi[k*COORD_W +: COORD_W] = COORD_W'(xi_v[k]);
            pts_yi[k*COORD_W +: COORD_W] = COORD_W'(yi_v[k]);
            pts_xo[k*COORD_W +: COORD_W] = COORD_W'(xo_v[k]);
            pts_yo[k*COORD_W +: COORD_W] = COORD_W'(yo_v[k]);
        end
        xb = COORD_W'(xb_v);
        yb = COORD_W'(yb_v);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!pts_ready && n < 20) begin
            tick();
            n++;
        end
        if (!pts_ready) chk("pts_ready_timeout", pts_ready, 1);
    endtask

    // Offers the current frame and checks every read pair plus the return to WAIT_PTS.
    task automatic run_frame();
        wait_ready();
        if (!pts_ready) return;
        drive_pts();
        pts_valid = 1'b1;
        tick();
        pts_valid = 1'b0;
        for (int k = 0; k <= NPTS; k++) begin
            if (k > 0) tick();
            chk("rd_valid", rd_valid, 1);
            chk("rd_idx", rd_idx, k);
            chk("addr_a", addr_a, exp_a[k]);
            chk("addr_b", addr_b, exp_b[k]);
            chk("oob_a", oob_a, exp_oa[k]);
            chk("oob_b", oob_b, exp_ob[k]);
            chk("done", done, (k == NPTS) ? 1 : 0);
            chk("scan_pts_ready", pts_ready, 0);
            chk("scan_we_a", we_a, 0);
        end
        tick();
        chk("post_rd_valid", rd_valid, 0);
        chk("post_done", done, 0);
        chk("post_pts_ready", pts_ready, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr_a"}, addr_a, 0);
        chk({tag, "_addr_b"}, addr_b, 0);
        chk({tag, "_we_a"}, we_a, 0);
        chk({tag, "_we_b"}, we_b, 0);
        chk({tag, "_wdata_a"}, wdata_a, 0);
        chk({tag, "_wdata_b"}, wdata_b, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_idx"}, rd_idx, 0);
        chk({tag, "_oob_a"}, oob_a, 0);
        chk({tag, "_oob_b"}, oob_b, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pts_ready"}, pts_ready, 0);
    endtask

    task automatic load_word(input int data, input bit last, input int ea, input int eb,
                             input int ewa, input int ewb);
        ld_valid = 1'b1;
        ld_last  = last;
        ld_data  = 16'(data);
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("ld_we_a", we_a, 1);
        chk("ld_we_b", we_b, 1);
        chk("ld_addr_a", addr_a, ea);
        chk("ld_addr_b", addr_b, eb);
        chk("ld_wdata_a", wdata_a, ewa);
        chk("ld_wdata_b", wdata_b, ewb);
        chk("ld_rd_valid", rd_valid, 0);
    endtask

    initial begin
        tbl[0] = '{x: 'h0050, y: 'h0020, exp_addr: 365,   exp_oob: 1'b0};
        tbl[1] = '{x: 'h0B30, y: 'h0B50, exp_addr: 32759, exp_oob: 1'b0};
        tbl[2] = '{x: 'h0B40, y: 'h0020, exp_addr: 0,     exp_oob: 1'b1};
        tbl[3] = '{x: 'h0000, y: 'h0000, exp_addr: 0,     exp_oob: 1'b0};
        tbl[4] = '{x: 'h0B3F, y: 'h0B5F, exp_addr: 32759, exp_oob: 1'b0};
        tbl[5] = '{x: 'h0000, y: 'h0B60, exp_addr: 0,     exp_oob: 1'b1};
        tbl[6] = '{x: 'h3FFF, y: 'h3FFF, exp_addr: 0,     exp_oob: 1'b1};
        tbl[7] = '{x: 'h0100, y: 'h0100, exp_addr: 2896,  exp_oob: 1'b0};

        rst = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
        pts_valid = 1'b0; pts_xi = '0; pts_yi = '0; pts_xo = '0; pts_yo = '0;
        xb = '0; yb = '0;
        tick();
        tick();
        chk_all_zero("reset");

        // Load three words, with an idle gap after the first.
        rst = 1'b0;
        start = 1'b1;
        tick();
        chk("idle_to_load_we", we_a, 0);
        load_word('hA1B2, 1'b0, 0, 1, 'hB2, 'hA1);
        chk("ld0_pts_ready", pts_ready, 0);
        tick();
        chk("ld_gap_we_a", we_a, 0);
        chk("ld_gap_we_b", we_b, 0);
        load_word('hC3D4, 1'b0, 2, 3, 'hD4, 'hC3);
        load_word('hE5F6, 1'b1, 4, 5, 'hF6, 'hE5);
        chk("ld_last_pts_ready", pts_ready, 1);

        // Directed frame: in-image port A point, port B just past the right edge,
        // base point at the last pixel.
        for (int k = 0; k < NPTS; k++) begin
            xi_v[k] = 'h100 * (k + 1); yi_v[k] = 'h80 * k;
            xo_v[k] = 'h200 + 'h10 * k; yo_v[k] = 'h300;
        end
        xi_v[0] = 'h0050; yi_v[0] = 'h0020;
        xo_v[0] = 'h0B40; yo_v[0] = 'h0020;
        xb_v = 'h0B30; yb_v = 'h0B50;
        model_frame();
        run_frame();

        // Table-driven boundary vectors: one coordinate on every point of both ports.
        foreach (tbl[t]) begin
            for (int k = 0; k < NPTS; k++) begin
                xi_v[k] = tbl[t].x; yi_v[k] = tbl[t].y;
                xo_v[k] = tbl[t].x; yo_v[k] = tbl[t].y;
            end
            xb_v = tbl[t].x; yb_v = tbl[t].y;
            for (int k = 0; k <= NPTS; k++) begin
                exp_a[k] = tbl[t].exp_addr; exp_oa[k] = tbl[t].exp_oob;
                exp_b[k] = tbl[t].exp_addr; exp_ob[k] = tbl[t].exp_oob;
            end
            run_frame();
        end

        // Random frames against the reference model.
        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < NPTS; k++) begin
                xi_v[k] = int'($urandom_range(0, 'h0C40));
                yi_v[k] = int'($urandom_range(0, 'h0C40));
                xo_v[k] = int'($urandom_range(0, 'h0C40));
                yo_v[k] = int'($urandom_range(0, 'h0C40));
            end
            xb_v = int'($urandom_range(0, 'h0C40));
            yb_v = int'($urandom_range(0, 'h0C40));
            model_frame();
            run_frame();
        end

        // Abort on the second SCAN cycle.
        wait_ready();
        drive_pts();
        pts_valid = 1'b1;
        tick();
        pts_valid = 1'b0;
        chk("abort_k0_rd_valid", rd_valid, 1);
        tick();
        chk("abort_k1_rd_idx", rd_idx, 1);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_rd_valid", rd_valid, 0);
            chk("abort_done", done, 0);
            chk("abort_pts_ready", pts_ready, 0);
            chk("abort_oob_a", oob_a, 0);
        end

        // Restart from IDLE: first cycle only moves to LOAD, then the word counter starts
        // at 0 and the load ends by itself on the last word of the image.
        start = 1'b1;
        ld_valid = 1'b1;
        ld_data = 16'h1122;
        tick();
        chk("restart_idle_we_a", we_a, 0);
        for (int i = 0; i < IMG_W * IMG_H / 2; i++) begin
            ld_data = 16'(i);
            tick();
            if (i == 0) begin
                chk("full_first_addr_a", addr_a, 0);
                chk("full_first_wdata_a", wdata_a, 0);
            end
            if (i == IMG_W * IMG_H / 2 - 2) begin
                chk("full_penult_pts_ready", pts_ready, 0);
                chk("full_penult_we_a", we_a, 1);
            end
            if (i == IMG_W * IMG_H / 2 - 1) begin
                chk("full_last_addr_a", addr_a, IMG_W * IMG_H - 2);
                chk("full_last_addr_b", addr_b, IMG_W * IMG_H - 1);
                chk("full_last_pts_ready", pts_ready, 1);
            end
        end
        tick();
        chk("full_after_we_a", we_a, 0);
        ld_valid = 1'b0;

        // Reset held for two cycles in the middle of SCAN.
        model_frame();
        wait_ready();
        drive_pts();
        pts_valid = 1'b1;
        tick();
        pts_valid = 1'b0;
        tick();
        chk("rst_pre_rd_valid", rd_valid, 1);
        rst = 1'b1;
        tick();
        chk_all_zero("midscan_rst1");
        tick();
        chk_all_zero("midscan_rst2");
        rst = 1'b0;
        tick();
        chk("post_rst_pts_ready", pts_ready, 0);
        chk("post_rst_rd_valid", rd_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
